mvm_feeder: RTL and testbench
=============================

# mvm_feeder

Stream-side front end for the matrix-vector multiplier core (`mvm_8_8_8_1` class). It accepts tagged matrix/vector/start beats over a valid/ready interface and stages each load group in a local buffer. It then replays the group to the core as the contiguous `loadMatrix`/`loadVector` bursts the core requires, issues `start`, captures the core's `MAT_SCALE` result words after `done`, and presents them downstream through a valid/ready result FIFO.

## Interface
- `MAT_SCALE`, 8, matrix dimension N (N×N matrix, N-element vector)
- `INPUT_WIDTH`, 8, signed element width
- `OUTPUT_WIDTH`, 2*`INPUT_WIDTH`, signed result width
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  beat accepted when `in_valid && in_ready` at a rising edge
- `in_cmd`  in  2  00 MATRIX, 01 VECTOR, 10 START, 11 reserved (beat accepted and dropped)
- `in_data`  in  `INPUT_WIDTH`  element value; ignored for START
- `loadMatrix`, `loadVector`, `start`  out  1 each  registered one-cycle pulses to the core
- `data_in`  out  `INPUT_WIDTH`  element word to the core
- `done`  in  1  core completion flag
- `data_out`  in  `OUTPUT_WIDTH`  core result word
- `out_valid`  out  1  result word available
- `out_ready`  in  1  downstream accepts a result word
- `out_data`  out  `OUTPUT_WIDTH`  result word, row 0 first
- `out_last`  out  1  high with row N-1
- `busy`  out  1  high in every state except IDLE

## Operation
- Stage buffer: N*N words. Group command is latched from the first beat of a group; `in_cmd` on later beats of the group is ignored.
- FSM states: IDLE, GATHER, PULSE, BURST, ISSUE, WAIT_DONE, CAPTURE.
- IDLE:
  - MATRIX/VECTOR head: accept beat 0, latch cmd, clear counter, go to GATHER. Group length is N*N for MATRIX and N for VECTOR.
  - START head: accepted only when the result FIFO is empty (`in_ready`=0 otherwise), then go to ISSUE.
- GATHER: `in_ready`=1. Each accepted beat is written at the counter address. After the last beat goes to PULSE. Gaps in `in_valid` only stall GATHER; they never reach the core.
- PULSE: assert `loadMatrix` or `loadVector` for exactly one cycle, then go to BURST.
- BURST: drive buffer words 0..len-1 on `data_in`, one per cycle with no gaps, then go to IDLE. `in_ready`=0.
- ISSUE: `start`=1 for one cycle, then go to WAIT_DONE.
- WAIT_DONE: hold until `done` is sampled 1. No timeout.
- CAPTURE: push `data_out` into the FIFO on each of the N rising edges following the edge at which `done` was sampled 1. Row N-1 is tagged `last`. Then go to IDLE.
- Result FIFO: depth N, show-ahead. Pops on `out_valid && out_ready`. Draining may overlap later GATHER/PULSE/BURST of new operands.
- Values pass through unmodified. No saturation; overflow is a caller concern.

## Timing
- Reset values: `in_ready` 0, `loadMatrix`/`loadVector`/`start` 0, `data_in` 0, `out_valid` 0, `out_data` 0, `out_last` 0, `busy` 0. The FSM enters IDLE, the FIFO empties, and any partial group is discarded.
- Reset mid-operation (any state): same result as above. The core's own reset is driven separately by the system.
- Last gather beat accepted at edge e: pulse high after e+1, word 0 on `data_in` after e+2, word k after e+2+k.
- START accepted at edge e: `start` high after e+1.
- `done` sampled at edge d: FIFO writes at d+1..d+N. `out_valid` is high after d+1.
- `data_in` holds the last burst word until the next burst.
- Simultaneous FIFO push and pop: both take effect. A push never meets a full FIFO because START requires the FIFO to be empty.

## Structure
- Package `mvm_pkg`: `cmd_t` enum (CMD_MATRIX, CMD_VECTOR, CMD_START, CMD_RSVD) and `state_t` enum for the seven FSM states.
- Sub-module `mvm_result_fifo` (parameters DEPTH, WIDTH+1 to carry the last bit).
- The stage buffer and FSM stay in `mvm_feeder`.

## Test plan
- Reset, then 64 contiguous MATRIX beats (values 1..64) -> `loadMatrix` pulses 1 cycle, then `data_in` = 1..64 on 64 consecutive cycles.
- 8 VECTOR beats with `in_valid` toggling every other cycle -> one `loadVector` pulse, then `data_in` = beats contiguous.
- Matrix = identity, x = {3,-5,0,7,-128,127,1,-1}, START, core model → `done` -> `out_data` = x sign-extended to 16 b, `out_last` on row 7.
- START while the FIFO holds 3 unread words (`out_ready`=0) -> `in_ready`=0 and no `start` until 3 pops occur.
- Reset asserted during BURST at word 20 -> all outputs at reset values. The next group restarts from word 0.
- Reserved cmd beat in IDLE -> accepted, no pulse on `loadMatrix`/`loadVector`/`start`, `busy` stays 0.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared types for the mvm_feeder block: stream command tags and FSM states.
package mvm_pkg;

    typedef enum logic [1:0] {
        CMD_MATRIX = 2'b00,
        CMD_VECTOR = 2'b01,
        CMD_START  = 2'b10,
        CMD_RSVD   = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATHER,
        S_PULSE,
        S_BURST,
        S_ISSUE,
        S_WAIT_DONE,
        S_CAPTURE
    } state_t;

endpackage

// File: rtl/mvm_feeder_if.sv
// Upstream beat stream and downstream result stream of the mvm_feeder.
interface mvm_feeder_if
    import mvm_pkg::*;
#(
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 2 * INPUT_WIDTH
);
    logic                    in_valid;
    logic                    in_ready;
    cmd_t                    in_cmd;
    logic [INPUT_WIDTH-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUTPUT_WIDTH-1:0] out_data;
    logic                    out_last;

    // Feeder side
    modport slave (
        input  in_valid, in_cmd, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    // Producer / consumer side
    modport master (
        output in_valid, in_cmd, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/mvm_result_fifo.sv
// Show-ahead result FIFO; output reads as zero while empty.
module mvm_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [NW-1:0]    count;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    assign dout   = valid ? mem[rd_ptr] : '0;

    // Storage write, no reset needed on the array
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= ptr_next(wr_ptr);
            if (do_pop) rd_ptr <= ptr_next(rd_ptr);
            case ({push, do_pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mvm_feeder.sv
// Stream front end for the matrix-vector core: stages load groups, replays
// them as contiguous bursts, issues start and buffers the result rows.
module mvm_feeder
    import mvm_pkg::*;
#(
    parameter int MAT_SCALE    = 8,
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 2 * INPUT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    mvm_feeder_if.slave             strm,
    output logic                    loadMatrix,
    output logic                    loadVector,
    output logic                    start,
    output logic [INPUT_WIDTH-1:0]  data_in,
    input  logic                    done,
    input  logic [OUTPUT_WIDTH-1:0] data_out,
    output logic                    busy
);
    localparam int          MAT_WORDS = MAT_SCALE * MAT_SCALE;
    localparam int          CW        = (MAT_WORDS > 1) ? $clog2(MAT_WORDS) : 1;
    localparam logic [CW-1:0] MAT_LAST = CW'(MAT_WORDS - 1);
    localparam logic [CW-1:0] VEC_LAST = CW'(MAT_SCALE - 1);

    state_t                  state;
    cmd_t                    grp_cmd;
    logic [CW-1:0]           cnt;
    logic                    rdy_q;
    logic                    in_rdy;
    logic                    accept;
    logic                    head_load;
    logic                    stage_we;
    logic [CW-1:0]           stage_addr;
    logic [CW-1:0]           head_last;
    logic [CW-1:0]           grp_last;
    logic [INPUT_WIDTH-1:0]  stage [MAT_WORDS];
    logic                    fifo_push;
    logic                    fifo_valid;
    logic [OUTPUT_WIDTH:0]   fifo_din;
    logic [OUTPUT_WIDTH:0]   fifo_dout;

    // A START head waits in IDLE until every previous result has been drained
    assign in_rdy     = rdy_q && !(state == S_IDLE && strm.in_cmd == CMD_START && fifo_valid);
    assign strm.in_ready = in_rdy;
    assign accept     = strm.in_valid && in_rdy;
    assign head_load  = (strm.in_cmd == CMD_MATRIX) || (strm.in_cmd == CMD_VECTOR);
    assign head_last  = (strm.in_cmd == CMD_MATRIX) ? MAT_LAST : VEC_LAST;
    assign grp_last   = (grp_cmd == CMD_MATRIX) ? MAT_LAST : VEC_LAST;
    assign stage_we   = accept && ((state == S_IDLE && head_load) || state == S_GATHER);
    assign stage_addr = (state == S_GATHER) ? cnt : '0;

    // Stage buffer write: group head lands at word 0, later beats at the counter
    always_ff @(posedge clk) begin
        if (stage_we) stage[stage_addr] <= strm.in_data;
    end

    // Control FSM with registered core strobes, ready and busy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            grp_cmd    <= CMD_MATRIX;
            cnt        <= '0;
            rdy_q      <= 1'b0;
            busy       <= 1'b0;
            loadMatrix <= 1'b0;
            loadVector <= 1'b0;
            start      <= 1'b0;
            data_in    <= '0;
        end else begin
            rdy_q      <= 1'b0;
            busy       <= 1'b1;
            loadMatrix <= 1'b0;
            loadVector <= 1'b0;
            start      <= 1'b0;
            case (state)
                S_IDLE: begin
                    rdy_q <= 1'b1;
                    busy  <= 1'b0;
                    if (accept) begin
                        case (strm.in_cmd)
                            CMD_MATRIX, CMD_VECTOR: begin
                                grp_cmd <= strm.in_cmd;
                                cnt     <= CW'(1);
                                busy    <= 1'b1;
                                if (head_last == '0) begin
                                    state <= S_PULSE;
                                    rdy_q <= 1'b0;
                                end else begin
                                    state <= S_GATHER;
                                end
                            end
                            CMD_START: begin
                                state <= S_ISSUE;
                                rdy_q <= 1'b0;
                                busy  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_GATHER: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == grp_last) begin
                            state <= S_PULSE;
                            rdy_q <= 1'b0;
                        end
                    end
                end
                S_PULSE: begin
                    loadMatrix <= (grp_cmd == CMD_MATRIX);
                    loadVector <= (grp_cmd == CMD_VECTOR);
                    cnt        <= '0;
                    state      <= S_BURST;
                end
                S_BURST: begin
                    data_in <= stage[cnt];
                    cnt     <= cnt + CW'(1);
                    if (cnt == grp_last) begin
                        state <= S_IDLE;
                        rdy_q <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    start <= 1'b1;
                    state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (done) begin
                        cnt   <= '0;
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == VEC_LAST) begin
                        state <= S_IDLE;
                        rdy_q <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign fifo_push = (state == S_CAPTURE);
    assign fifo_din  = {cnt == VEC_LAST, data_out};

    mvm_result_fifo #(
        .DEPTH (MAT_SCALE),
        .WIDTH (OUTPUT_WIDTH + 1)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (strm.out_ready),
        .valid (fifo_valid),
        .dout  (fifo_dout)
    );

    assign strm.out_valid = fifo_valid;
    assign strm.out_last  = fifo_dout[OUTPUT_WIDTH];
    assign strm.out_data  = fifo_dout[OUTPUT_WIDTH-1:0];
endmodule

// File: tb/tb_mvm_feeder.sv
// Directed bench for mvm_feeder with a behavioural matrix-vector core.
module tb_mvm_feeder;
    import mvm_pkg::*;

    logic        clk;
    logic        reset;
    logic        loadMatrix;
    logic        loadVector;
    logic        start;
    logic [7:0]  data_in;
    logic        done;
    logic [15:0] data_out;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic signed [7:0] core_mat [64];
    logic signed [7:0] core_vec [8];
    logic [15:0]       exp_y [8];

    mvm_feeder_if #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(16)) bus ();

    mvm_feeder #(
        .MAT_SCALE    (8),
        .INPUT_WIDTH  (8),
        .OUTPUT_WIDTH (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .strm       (bus),
        .loadMatrix (loadMatrix),
        .loadVector (loadVector),
        .start      (start),
        .data_in    (data_in),
        .done       (done),
        .data_out   (data_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural core: records bursts, answers start with done and 8 rows
    initial begin
        int acc;
        done     = 1'b0;
        data_out = '0;
        forever begin
            @(posedge clk); #1;
            if (reset && loadMatrix) begin
                for (int k = 0; k < 64; k++) begin
                    @(posedge clk); #1;
                    if (!reset) break;
                    core_mat[k] = data_in;
                end
            end else if (reset && loadVector) begin
                for (int k = 0; k < 8; k++) begin
                    @(posedge clk); #1;
                    if (!reset) break;
                    core_vec[k] = data_in;
                end
            end else if (reset && start) begin
                repeat (3) @(posedge clk);
                #1 done = 1'b1;
                for (int r = 0; r < 8; r++) begin
                    @(posedge clk); #1;
                    done = 1'b0;
                    acc  = 0;
                    for (int j = 0; j < 8; j++) acc += core_mat[r*8+j] * core_vec[j];
                    data_out = 16'(acc);
                end
                @(posedge clk);
            end
        end
    end

    // Drive one beat and hold it until accepted
    task automatic beat(input cmd_t c, input logic [7:0] d);
        int unsigned guard = 0;
        bus.in_valid = 1'b1;
        bus.in_cmd   = c;
        bus.in_data  = d;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            guard++;
            if (guard > 200) break;
        end
        if (guard > 200) begin
            failures++;
            $display("FAIL beat_accept: in_ready stayed 0, required 1 within 200 cycles");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Bounded wait for busy to drop
    task automatic wait_idle();
        int unsigned guard = 0;
        while (busy && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_cmd    = CMD_MATRIX;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.in_ready, loadMatrix, loadVector, start, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: in_ready/lm/lv/start/busy=%b required 00000",
                     {bus.in_ready, loadMatrix, loadVector, start, busy});
        end
        checks++;
        if (data_in !== 8'h00) begin
            failures++;
            $display("FAIL reset_data_in: got %h required 00", data_in);
        end
        checks++;
        if ({bus.out_valid, bus.out_last, bus.out_data} !== 18'h0) begin
            failures++;
            $display("FAIL reset_out: valid/last/data=%b/%b/%h required 0/0/0000",
                     bus.out_valid, bus.out_last, bus.out_data);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_matrix_burst();
        for (int k = 0; k < 64; k++) beat(CMD_MATRIX, 8'(k + 1));
        checks++;
        if (loadMatrix !== 1'b0) begin
            failures++;
            $display("FAIL mat_pulse_early: loadMatrix=%b required 0", loadMatrix);
        end
        @(posedge clk); #1;
        checks++;
        if ({loadMatrix, loadVector, busy, bus.in_ready} !== 4'b1010) begin
            failures++;
            $display("FAIL mat_pulse: lm/lv/busy/in_ready=%b required 1010",
                     {loadMatrix, loadVector, busy, bus.in_ready});
        end
        for (int k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            checks++;
            if (data_in !== 8'(k + 1) || loadMatrix !== 1'b0) begin
                failures++;
                $display("FAIL mat_word%0d: data_in=%h lm=%b required %h lm=0",
                         k, data_in, loadMatrix, 8'(k + 1));
            end
        end
        @(posedge clk); #1;
        checks++;
        if (data_in !== 8'd64 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mat_hold: data_in=%h busy=%b required 40 busy=0", data_in, busy);
        end
    endtask

    task automatic test_vector_gaps();
        logic [7:0] x [8];
        x = '{8'd3, 8'hFB, 8'd0, 8'd7, 8'h80, 8'h7F, 8'd1, 8'hFF};
        for (int k = 0; k < 8; k++) begin
            beat(CMD_VECTOR, x[k]);
            if (k < 7) begin
                @(negedge clk);
                checks++;
                if ({loadVector, loadMatrix} !== 2'b00 || data_in !== 8'd64) begin
                    failures++;
                    $display("FAIL vec_gap%0d: lv/lm=%b data_in=%h required 00 and 40",
                             k, {loadVector, loadMatrix}, data_in);
                end
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({loadVector, loadMatrix} !== 2'b10) begin
            failures++;
            $display("FAIL vec_pulse: lv/lm=%b required 10", {loadVector, loadMatrix});
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (data_in !== x[k] || loadVector !== 1'b0) begin
                failures++;
                $display("FAIL vec_word%0d: data_in=%h lv=%b required %h lv=0",
                         k, data_in, loadVector, x[k]);
            end
        end
    endtask

    task automatic test_identity();
        int unsigned guard = 0;
        exp_y = '{16'h0003, 16'hFFFB, 16'h0000, 16'h0007,
                  16'hFF80, 16'h007F, 16'h0001, 16'hFFFF};
        for (int k = 0; k < 64; k++) beat(CMD_MATRIX, (k % 9 == 0) ? 8'd1 : 8'd0);
        beat(CMD_START, 8'hAA);
        @(posedge clk); #1;
        checks++;
        if (start !== 1'b1) begin
            failures++;
            $display("FAIL id_start: start=%b required 1", start);
        end
        forever begin
            @(negedge clk);
            if (done || guard > 50) break;
            guard++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL id_done_seen: done=%b required 1", done);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL id_valid_early: out_valid=%b required 0", bus.out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_y[0]) begin
            failures++;
            $display("FAIL id_first_row: out_valid=%b data=%h required 1 %h",
                     bus.out_valid, bus.out_data, exp_y[0]);
        end
        wait_idle();
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_y[r] || bus.out_last !== 1'b0) begin
                failures++;
                $display("FAIL id_row%0d: valid=%b data=%h last=%b required 1 %h 0",
                         r, bus.out_valid, bus.out_data, bus.out_last, exp_y[r]);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_start_blocked();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_cmd    = CMD_START;
        bus.in_data   = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0 || start !== 1'b0) begin
                failures++;
                $display("FAIL blk_hold: in_ready=%b start=%b required 0 0", bus.in_ready, start);
            end
            @(posedge clk); #1;
        end
        for (int r = 5; r < 8; r++) begin
            @(negedge clk);
            checks++;
            if (bus.out_data !== exp_y[r] || bus.out_last !== (r == 7) || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL blk_row%0d: data=%h last=%b in_ready=%b required %h %b 0",
                         r, bus.out_data, bus.out_last, bus.in_ready, exp_y[r], r == 7);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || start !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL blk_release: in_ready=%b start=%b out_valid=%b required 1 0 0",
                     bus.in_ready, start, bus.out_valid);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (start !== 1'b1) begin
            failures++;
            $display("FAIL blk_start: start=%b required 1", start);
        end
        repeat (4) @(posedge clk);
        #1;
        wait_idle();
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_y[r] || bus.out_last !== (r == 7)) begin
                failures++;
                $display("FAIL blk2_row%0d: valid=%b data=%h last=%b required 1 %h %b",
                         r, bus.out_valid, bus.out_data, bus.out_last, exp_y[r], r == 7);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset_burst();
        for (int k = 0; k < 64; k++) beat(CMD_MATRIX, 8'(k * 3));
        @(posedge clk); #1;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (data_in !== 8'd60) begin
            failures++;
            $display("FAIL rb_word20: data_in=%h required 3c", data_in);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, loadMatrix, loadVector, start, busy, bus.out_valid, bus.out_last} !== 7'b0
            || data_in !== 8'h00 || bus.out_data !== 16'h0000) begin
            failures++;
            $display("FAIL rb_reset: ctrl=%b data_in=%h out_data=%h required 0000000 00 0000",
                     {bus.in_ready, loadMatrix, loadVector, start, busy, bus.out_valid, bus.out_last},
                     data_in, bus.out_data);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 8; k++) beat(CMD_VECTOR, 8'(k + 11));
        @(posedge clk); #1;
        checks++;
        if (loadVector !== 1'b1) begin
            failures++;
            $display("FAIL rb_vpulse: loadVector=%b required 1", loadVector);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (data_in !== 8'(k + 11)) begin
                failures++;
                $display("FAIL rb_word%0d: data_in=%h required %h", k, data_in, 8'(k + 11));
            end
        end
    endtask

    task automatic test_reserved();
        beat(CMD_RSVD, 8'h55);
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({loadMatrix, loadVector, start, busy} !== 4'b0000 || bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL rsvd: lm/lv/start/busy=%b in_ready=%b required 0000 1",
                         {loadMatrix, loadVector, start, busy}, bus.in_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_matrix_burst();
        test_vector_gaps();
        test_identity();
        test_start_blocked();
        test_reset_burst();
        test_reserved();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
